// File: rtl/demux_pkg.sv
// Shared constants and channel state encoding for the registered 1:4 write demux.
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;
endpackage

// File: rtl/demux_1t4_nb_reg_if.sv
// Write-side bus plus per-channel consumer handshake for demux_1t4_nb_reg.
interface demux_1t4_nb_reg_if #(parameter int n = 8) ();
  import demux_pkg::*;

  logic [SEL_W-1:0]  SEL;
  logic [n-1:0]      D_IN;
  logic              WE;
  logic              BUSY;
  logic [n-1:0]      D0, D1, D2, D3;
  logic [NUM_CH-1:0] VLD;
  logic [NUM_CH-1:0] ACK;
  logic [NUM_CH-1:0] OVF;
  logic              CLR_OVF;

  // core + consumers side
  modport master (
    output SEL, D_IN, WE, ACK, CLR_OVF,
    input  BUSY, D0, D1, D2, D3, VLD, OVF
  );

  // demux side
  modport slave (
    input  SEL, D_IN, WE, ACK, CLR_OVF,
    output BUSY, D0, D1, D2, D3, VLD, OVF
  );
endinterface

// File: rtl/demux_slot.sv
// One channel: holding register, EMPTY/FULL valid state and sticky overflow.
module demux_slot
  import demux_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic         ack,
  input  logic         clr_ovf,
  input  logic [n-1:0] d_in,
  output logic [n-1:0] d,
  output logic         vld,
  output logic         ovf
);
  ch_state_e    state_q, state_d;
  logic [n-1:0] d_q, d_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    ovf_d   = ovf_q & ~clr_ovf;
    unique case (state_q)
      CH_EMPTY: begin
        if (wr) begin
          d_d     = d_in;
          state_d = CH_FULL;
        end
      end
      CH_FULL: begin
        // ack with a write refills in place so valid never bubbles;
        // a write without ack is dropped and the drop outranks clr_ovf
        if (wr) begin
          if (ack) d_d = d_in;
          else     ovf_d = 1'b1;
        end else if (ack) begin
          state_d = CH_EMPTY;
        end
      end
      default: state_d = CH_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_EMPTY;
      d_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      ovf_q   <= ovf_d;
    end
  end

  assign d   = d_q;
  assign vld = (state_q == CH_FULL);
  assign ovf = ovf_q;
endmodule

// File: rtl/demux_1t4_nb_reg.sv
// Registered 1:4 write demux: SEL decode, BUSY mux and four handshaked channel slots.
module demux_1t4_nb_reg
  import demux_pkg::*;
#(
  parameter int n = 8
) (
  input logic                   CLK,
  input logic                   RST_N,
  demux_1t4_nb_reg_if.slave     bus
);
  logic [NUM_CH-1:0]        wr;
  logic [NUM_CH-1:0]        vld;
  logic [NUM_CH-1:0]        ovf;
  logic [NUM_CH-1:0][n-1:0] d;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign wr[k] = bus.WE & (bus.SEL == SEL_W'(k));

    demux_slot #(.n(n)) u_slot (
      .clk     (CLK),
      .rst_n   (RST_N),
      .wr      (wr[k]),
      .ack     (bus.ACK[k]),
      .clr_ovf (bus.CLR_OVF),
      .d_in    (bus.D_IN),
      .d       (d[k]),
      .vld     (vld[k]),
      .ovf     (ovf[k])
    );
  end

  // BUSY reflects the addressed channel regardless of WE
  assign bus.BUSY = vld[bus.SEL] & ~bus.ACK[bus.SEL];
  assign bus.VLD  = vld;
  assign bus.OVF  = ovf;
  assign bus.D0   = d[0];
  assign bus.D1   = d[1];
  assign bus.D2   = d[2];
  assign bus.D3   = d[3];
endmodule

// File: tb/tb_demux_1t4_nb_reg.sv
// Directed self-checking bench for demux_1t4_nb_reg at n=8 and n=16.
module tb_demux_1t4_nb_reg;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  demux_1t4_nb_reg_if #(.n(8))  bus8 ();
  demux_1t4_nb_reg_if #(.n(16)) bus16 ();

  demux_1t4_nb_reg #(.n(8))  dut8  (.CLK(clk), .RST_N(rst_n), .bus(bus8));
  demux_1t4_nb_reg #(.n(16)) dut16 (.CLK(clk), .RST_N(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus8.SEL = 2'd2; bus8.D_IN = 8'hA5; bus8.WE = 1'b1;
    bus8.ACK = 4'b0000; bus8.CLR_OVF = 1'b0;
    bus16.SEL = 2'd0; bus16.D_IN = 16'h0; bus16.WE = 1'b0;
    bus16.ACK = 4'b0000; bus16.CLR_OVF = 1'b0;

    // writes held off while in reset
    tick(); tick();
    chk("rst_d0",   32'(bus8.D0),   32'h0);
    chk("rst_d1",   32'(bus8.D1),   32'h0);
    chk("rst_d2",   32'(bus8.D2),   32'h0);
    chk("rst_d3",   32'(bus8.D3),   32'h0);
    chk("rst_vld",  32'(bus8.VLD),  32'h0);
    chk("rst_ovf",  32'(bus8.OVF),  32'h0);
    chk("rst_busy", 32'(bus8.BUSY), 32'h0);

    // async reset mid-handshake
    rst_n = 1'b1;
    bus8.WE = 1'b0;
    tick();
    bus8.WE = 1'b1; bus8.SEL = 2'd2; bus8.D_IN = 8'h5A;
    tick();
    bus8.WE = 1'b0;
    chk("pre_async_vld", 32'(bus8.VLD), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_vld", 32'(bus8.VLD), 32'h0);
    chk("async_d2",  32'(bus8.D2),  32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic steer
    for (int i = 0; i < 4; i++) begin
      bus8.WE = 1'b1; bus8.SEL = 2'(i); bus8.D_IN = 8'(8'h11 * (i + 1));
      tick();
    end
    bus8.WE = 1'b0;
    chk("steer_d0",  32'(bus8.D0),  32'h11);
    chk("steer_d1",  32'(bus8.D1),  32'h22);
    chk("steer_d2",  32'(bus8.D2),  32'h33);
    chk("steer_d3",  32'(bus8.D3),  32'h44);
    chk("steer_vld", 32'(bus8.VLD), 32'hF);
    for (int s = 0; s < 4; s++) begin
      bus8.SEL = 2'(s);
      #1;
      chk("steer_busy", 32'(bus8.BUSY), 32'h1);
    end

    // handshake on ch1
    bus8.ACK = 4'b0010;
    bus8.SEL = 2'd1;
    #1;
    chk("ack_busy_comb", 32'(bus8.BUSY), 32'h0);
    tick();
    bus8.ACK = 4'b0000;
    chk("ack_vld", 32'(bus8.VLD), 32'hD);
    chk("ack_d1",  32'(bus8.D1),  32'h22);
    #1;
    chk("ack_busy", 32'(bus8.BUSY), 32'h0);

    // simultaneous ack + write on ch3
    bus8.ACK = 4'b1000; bus8.WE = 1'b1; bus8.SEL = 2'd3; bus8.D_IN = 8'h99;
    #1;
    chk("sim_busy", 32'(bus8.BUSY), 32'h0);
    tick();
    bus8.ACK = 4'b0000; bus8.WE = 1'b0;
    chk("sim_d3",  32'(bus8.D3),     32'h99);
    chk("sim_vld", 32'(bus8.VLD[3]), 32'h1);
    chk("sim_ovf", 32'(bus8.OVF),    32'h0);

    // overflow on ch0, then clear, then clear vs set
    bus8.WE = 1'b1; bus8.SEL = 2'd0; bus8.D_IN = 8'hEE;
    tick();
    bus8.WE = 1'b0;
    chk("ovf_d0",  32'(bus8.D0),  32'h11);
    chk("ovf_set", 32'(bus8.OVF), 32'h1);
    bus8.CLR_OVF = 1'b1;
    tick();
    bus8.CLR_OVF = 1'b0;
    chk("ovf_clr", 32'(bus8.OVF), 32'h0);
    bus8.CLR_OVF = 1'b1; bus8.WE = 1'b1; bus8.SEL = 2'd0; bus8.D_IN = 8'h77;
    tick();
    bus8.CLR_OVF = 1'b0; bus8.WE = 1'b0;
    chk("ovf_set_wins", 32'(bus8.OVF), 32'h1);
    chk("ovf_d0_keep",  32'(bus8.D0),  32'h11);

    // multiple acks drain all, then acks on empty are ignored
    bus8.ACK = 4'b1101;
    tick();
    chk("multi_ack_vld", 32'(bus8.VLD), 32'h0);
    bus8.ACK = 4'b1111;
    tick();
    bus8.ACK = 4'b0000;
    chk("empty_ack_vld", 32'(bus8.VLD), 32'h0);
    chk("empty_ack_d0",  32'(bus8.D0),  32'h11);
    chk("empty_ack_d3",  32'(bus8.D3),  32'h99);

    // 16-bit instance
    bus16.WE = 1'b1; bus16.SEL = 2'd2; bus16.D_IN = 16'hBEEF;
    tick();
    bus16.WE = 1'b0;
    chk("w16_d2",  32'(bus16.D2),  32'hBEEF);
    chk("w16_d0",  32'(bus16.D0),  32'h0);
    chk("w16_d1",  32'(bus16.D1),  32'h0);
    chk("w16_d3",  32'(bus16.D3),  32'h0);
    chk("w16_vld", 32'(bus16.VLD), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
